can_tx: RTL and testbench

Simplified CAN 2.0A transmitter that serialises one standard data frame per request: 11-bit identifier, 1-byte payload, DLC fixed at 1.
- Transmits one bus bit per clock cycle; an external bit-timing stage sits between this block and the PHY.
- Performs bit stuffing, CRC-15 generation and arbitration monitoring through the `rx` bus-sense input.
- Sits between the node's message logic and the CAN transceiver.

---
 rtl/can_tx_if.sv | 28 ++
 rtl/can_tx.sv | 174 +++++++++++++++++
 tb/tb_can_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_if.sv
// ============================================================================
//  Module   : can_tx_if
//  Brief    : Message-side and bus-side signals of the CAN 2.0A transmitter
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface can_tx_if;
  logic        rx;
  logic [10:0] address;
  logic [7:0]  data;
  logic        send_data;
  logic        clear_to_tx;
  logic        tx;
  logic        txing;

  modport master (
    output rx, address, data, send_data, clear_to_tx,
    input  tx, txing
  );

  modport slave (
    input  rx, address, data, send_data, clear_to_tx,
    output tx, txing
  );
endinterface

`default_nettype wire

// File: rtl/can_tx.sv
// ============================================================================
//  Module   : can_tx
//  Brief    : CAN 2.0A standard data frame transmitter (11-bit ID, 1 data
//             byte) with bit stuffing, CRC-15 and arbitration monitoring
//  Revision : 1.0
// ============================================================================
`default_nettype none

module can_tx (
  input  wire logic clk,
  input  wire logic rst,
  can_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_IFS   = 2'd2
  } state_t;

  localparam logic [14:0] c_crc_poly  = 15'h4599;
  localparam logic [5:0]  c_last_data = 6'd26;
  localparam logic [5:0]  c_last_crc  = 6'd41;
  localparam logic [5:0]  c_last_eof  = 6'd51;
  localparam logic [5:0]  c_arb_first = 6'd1;
  localparam logic [5:0]  c_arb_last  = 6'd12;
  localparam logic [2:0]  c_run_max   = 3'd5;
  localparam logic [1:0]  c_ifs_last  = 2'd2;

  state_t      state_q, state_d;
  logic        tx_q, tx_d;
  logic        txing_q, txing_d;
  logic [26:0] sh_q, sh_d;
  logic [14:0] crc_q, crc_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  run_q, run_d;
  logic        stuff_q, stuff_d;
  logic [1:0]  ifs_q, ifs_d;

  logic        w_req;
  logic [5:0]  w_next_idx;
  logic        w_next_bit;
  logic        w_arb_lost;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [14:0] s;
    s = {c[13:0], 1'b0};
    if (b ^ c[14]) s = s ^ c_crc_poly;
    return s;
  endfunction

  assign w_req      = bus.send_data & bus.clear_to_tx;
  assign w_next_idx = bitcnt_q + 6'd1;
  assign w_next_bit = (w_next_idx <= c_last_data) ? sh_q[26] :
                      (w_next_idx <= c_last_crc)  ? crc_q[14] : 1'b1;
  // Only genuine ID/RTR bits arbitrate; stuff bits in that range do not.
  assign w_arb_lost = !stuff_q && (bitcnt_q >= c_arb_first) &&
                      (bitcnt_q <= c_arb_last) && tx_q && !bus.rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      txing_q  <= 1'b0;
      sh_q     <= '0;
      crc_q    <= '0;
      bitcnt_q <= '0;
      run_q    <= '0;
      stuff_q  <= 1'b0;
      ifs_q    <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      txing_q  <= txing_d;
      sh_q     <= sh_d;
      crc_q    <= crc_d;
      bitcnt_q <= bitcnt_d;
      run_q    <= run_d;
      stuff_q  <= stuff_d;
      ifs_q    <= ifs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    txing_d  = txing_q;
    sh_d     = sh_q;
    crc_d    = crc_q;
    bitcnt_d = bitcnt_q;
    run_d    = run_q;
    stuff_d  = stuff_q;
    ifs_d    = ifs_q;

    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        txing_d = 1'b0;
        if (w_req) begin
          state_d  = S_FRAME;
          tx_d     = 1'b0;
          txing_d  = 1'b1;
          sh_d     = {bus.address, 7'b0000001, bus.data, 1'b0};
          crc_d    = '0;
          bitcnt_d = '0;
          run_d    = 3'd1;
          stuff_d  = 1'b0;
        end
      end

      S_FRAME: begin
        if (w_arb_lost) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          txing_d = 1'b0;
        end else if ((run_q == c_run_max) && (bitcnt_q <= c_last_crc)) begin
          tx_d    = ~tx_q;
          stuff_d = 1'b1;
          run_d   = 3'd1;
        end else if (bitcnt_q == c_last_eof) begin
          state_d = S_IFS;
          tx_d    = 1'b1;
          txing_d = 1'b0;
          ifs_d   = '0;
        end else begin
          tx_d     = w_next_bit;
          bitcnt_d = w_next_idx;
          stuff_d  = 1'b0;
          if (w_next_idx <= c_last_data) begin
            sh_d  = {sh_q[25:0], 1'b0};
            crc_d = crc_step(crc_q, w_next_bit);
          end else if (w_next_idx <= c_last_crc) begin
            crc_d = {crc_q[13:0], 1'b0};
          end
          if (w_next_idx <= c_last_crc)
            run_d = (w_next_bit == tx_q) ? run_q + 3'd1 : 3'd1;
        end
      end

      S_IFS: begin
        tx_d    = 1'b1;
        txing_d = 1'b0;
        if (ifs_q == c_ifs_last) begin
          // The edge closing the third intermission cycle acts as the first idle edge.
          state_d = S_IDLE;
          if (w_req) begin
            state_d  = S_FRAME;
            tx_d     = 1'b0;
            txing_d  = 1'b1;
            sh_d     = {bus.address, 7'b0000001, bus.data, 1'b0};
            crc_d    = '0;
            bitcnt_d = '0;
            run_d    = 3'd1;
            stuff_d  = 1'b0;
          end
        end else begin
          ifs_d = ifs_q + 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        txing_d = 1'b0;
      end
    endcase
  end

  assign bus.tx    = tx_q;
  assign bus.txing = txing_q;

endmodule

`default_nettype wire

// File: tb/tb_can_tx.sv
// ============================================================================
//  Module   : tb_can_tx
//  Brief    : Self-checking bench for can_tx with a bit-level frame model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_can_tx;

  logic clk = 1'b0;
  logic rst;
  logic force_en;
  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_q[$];

  can_tx_if bus ();

  // Bus loopback; force_en pulls the sensed level dominant.
  assign bus.rx = force_en ? 1'b0 : bus.tx;

  can_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic obs, input logic exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [10:0] id, input logic [7:0] d);
    logic        ub[0:51];
    logic [14:0] crc;
    logic        fb;
    logic        prev;
    int          run;
    ub[0] = 1'b0;
    for (int i = 0; i < 11; i++) ub[1 + i] = id[10 - i];
    ub[12] = 1'b0; ub[13] = 1'b0; ub[14] = 1'b0;
    ub[15] = 1'b0; ub[16] = 1'b0; ub[17] = 1'b0; ub[18] = 1'b1;
    for (int i = 0; i < 8; i++) ub[19 + i] = d[7 - i];
    crc = '0;
    for (int i = 0; i <= 26; i++) begin
      fb  = ub[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 0; i < 15; i++) ub[27 + i] = crc[14 - i];
    for (int i = 42; i <= 51; i++) ub[i] = 1'b1;
    run  = 0;
    prev = 1'b0;
    for (int i = 0; i <= 51; i++) begin
      exp_q.push_back(ub[i]);
      if (i <= 41) begin
        if (i > 0 && ub[i] == prev) run++;
        else run = 1;
        prev = ub[i];
        if (run == 5) begin
          exp_q.push_back(~prev);
          prev = ~prev;
          run  = 1;
        end
      end
    end
  endtask

  task automatic wait_accept(input int max_cycles, input string tag, output bit got);
    got = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(posedge clk); #1;
      if (bus.txing === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(got, 1'b1, {tag, " accept"});
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk(bus.tx,    1'b1, $sformatf("%s tx cyc %0d", tag, k));
      chk(bus.txing, 1'b0, $sformatf("%s txing cyc %0d", tag, k));
    end
  endtask

  task automatic run_frame(input int max_wait, input bit drop_req, input int mod_at,
                           input logic [10:0] na, input logic [7:0] nd, input string tag);
    bit   got;
    int   idx;
    logic e;
    wait_accept(max_wait, tag, got);
    if (drop_req) bus.send_data = 1'b0;
    if (!got) begin
      exp_q.delete();
      return;
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(bus.tx,    e,    $sformatf("%s bit %0d", tag, idx));
      chk(bus.txing, 1'b1, $sformatf("%s txing %0d", tag, idx));
      idx++;
      if (idx == mod_at) begin
        bus.address = na;
        bus.data    = nd;
      end
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bit got;
    rst             = 1'b1;
    force_en        = 1'b0;
    bus.send_data   = 1'b1;
    bus.clear_to_tx = 1'b1;
    bus.address     = 11'b10101010111;
    bus.data        = 8'hCC;

    // Reset held with a pending request
    repeat (4) begin
      @(posedge clk); #1;
      chk(bus.tx,    1'b1, "reset tx");
      chk(bus.txing, 1'b0, "reset txing");
    end
    bus.clear_to_tx = 1'b0;
    rst = 1'b0;
    check_idle(2, "post-reset");

    // Basic frame 0x557 / 0xCC
    push_frame(11'h557, 8'hCC);
    bus.clear_to_tx = 1'b1;
    run_frame(1, 1'b1, -1, 11'h0, 8'h0, "basic");
    check_idle(5, "basic ifs");

    // Gating by clear_to_tx
    bus.address     = 11'h7FF;
    bus.data        = 8'h00;
    bus.send_data   = 1'b1;
    bus.clear_to_tx = 1'b0;
    check_idle(20, "gate");
    push_frame(11'h7FF, 8'h00);
    bus.clear_to_tx = 1'b1;
    run_frame(1, 1'b1, -1, 11'h0, 8'h0, "gated");
    check_idle(3, "gated ifs");

    // Arbitration loss on ID[10]
    bus.address   = 11'h557;
    bus.data      = 8'hCC;
    bus.send_data = 1'b1;
    wait_accept(1, "arb", got);
    bus.send_data = 1'b0;
    chk(bus.tx, 1'b0, "arb sof");
    force_en = 1'b1;
    @(posedge clk); #1;
    chk(bus.tx,    1'b1, "arb id10 tx");
    chk(bus.txing, 1'b1, "arb id10 txing");
    @(posedge clk); #1;
    chk(bus.tx,    1'b1, "arb lost tx");
    chk(bus.txing, 1'b0, "arb lost txing");
    force_en = 1'b0;
    check_idle(3, "arb idle");

    // Latching and back-to-back
    bus.address   = 11'h557;
    bus.data      = 8'hCC;
    bus.send_data = 1'b1;
    push_frame(11'h557, 8'hCC);
    run_frame(1, 1'b0, 20, 11'h555, 8'hCF, "b2b1");
    check_idle(3, "b2b ifs");
    push_frame(11'h555, 8'hCF);
    run_frame(1, 1'b1, -1, 11'h0, 8'h0, "b2b2");
    check_idle(3, "b2b2 ifs");

    // Asynchronous reset mid-frame, then a clean frame
    bus.address   = 11'h000;
    bus.data      = 8'h00;
    bus.send_data = 1'b1;
    wait_accept(1, "midrst", got);
    bus.send_data = 1'b0;
    repeat (24) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(bus.tx,    1'b1, "async rst tx");
    chk(bus.txing, 1'b0, "async rst txing");
    @(posedge clk); #1;
    chk(bus.tx,    1'b1, "rst held tx");
    chk(bus.txing, 1'b0, "rst held txing");
    rst = 1'b0;
    check_idle(2, "post midrst");
    bus.address   = 11'h6B3;
    bus.data      = 8'hA5;
    push_frame(11'h6B3, 8'hA5);
    bus.send_data = 1'b1;
    run_frame(1, 1'b1, -1, 11'h0, 8'h0, "after rst");
    check_idle(3, "final ifs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
